atahost_pio_dtseq: RTL
======================

# atahost_pio_dtseq

PIO transfer sequencer for the OCIDEC-2 generation ATA host. It generates ATA-3 PIO cycles (DA, CSn, DIORn/DIOWn, DD direction) with three programmable timing sets: the shared command-port set, plus one fast data-port set for each of device 0 and device 1. It tracks the selected device by shadowing writes to the Device/Head register. It sits between the WISHBONE register/decoder top and the ATA pads, replacing the single-timing controller.

## Interface
- TWIDTH, 8, timing counter width
- T1_RST, 6, reset T1 of all sets (70 ns at 100 MHz)
- T2_RST, 28, reset T2 (290 ns)
- T4_RST, 2, reset T4 (30 ns)
- TEOC_RST, 23, reset Teoc (240 ns)

Ports:
- wb_clk_i  in  1  clock
- rst_nreset_i  in  1  reset, asynchronous, active-low
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  write timing set selected by cfg_sel
- cfg_sel  in  2  0 = command port, 1 = device 0 data port, 2 = device 1 data port, 3 = reserved
- cfg_d  in  4*TWIDTH  {Teoc,T4,T2,T1}
- cfg_q  out  4*TWIDTH  set selected by cfg_sel (combinational; 0 for sel 3)
- iordy_en  in  3  IORDY enable per set, indexed like cfg_sel
- req  in  1  transfer request, held until ack
- we  in  1  1 = write
- a  in  4  a[3] = CS1 select, a[2:0] = DA
- d  in  16  write data
- q  out  16  read data (registered)
- ack  out  1  one-cycle transfer acknowledge
- busy  out  1  high whenever state ≠ IDLE
- da  out  3;  cs0n, cs1n, diorn, diown  out  1;  ddo  out  16;  ddoe  out  1
- iordy  in  1  asynchronous, from pad

## Operation
- States: IDLE, T1, T2, T2W, T4, TEOC.
- IDLE with req=1: accept the request and snapshot a, we, d, the selected timing set, and its iordy_en, then go to T1.
- Set selection: a == 4'b0000 (data register) uses set 1+dev; all other addresses use set 0.
- Device/Head shadow: a write accepted with a == 4'b0110 loads dev <= d[4]. The write itself uses set 0 timing.
- T1: da/csn driven, strobes negated. Phase lasts T1+1 clocks, then go to T2.
- T2: diorn/diown asserted. After T2+1 clocks:
  - iordy wait applies (snapshot iordy_en = 1 and iordy_s = 0): go to T2W.
  - Otherwise: negate the strobe and go to T4.
- T2W: strobe held asserted until iordy_s = 1. The strobe negates on the following edge; no timeout.
- Leaving T2/T2W: q <= DDi (reads), ack <= 1 for one cycle (reads and writes).
- T4: strobes negated, address held. Lasts T4+1 clocks.
- TEOC: csn negated (both 1), da held. Lasts Teoc+1 clocks, then IDLE.
- ddoe: 1 from T1 entry through the last T4 cycle, writes only. ddo = snapshot d.
- A timing value of 0 gives a 1-clock phase. Counters are unsigned, with no wrap.
- cfg writes during a transfer update the registers but not the in-flight snapshot.
- req dropping mid-transfer is ignored; the transfer completes and ack still pulses.

## Timing
- iordy passes through a 2-flop synchronizer (iordy_s), adding 2 clocks of wait latency.
- ack is high in the cycle starting T1+T2+2 edges after the accepting edge (no IORDY wait). Defaults: 36.
- Full cycle, accept to next possible accept: T1+T2+T4+Teoc+4 edges. Defaults: 63.
- Reset (either) forces IDLE. Outputs in reset:
  - cs0n = cs1n = diorn = diown = 1
  - ddoe = 0, ack = 0, busy = 0
  - da = 0, ddo = 0, q = 0
  - dev = 0, all sets = *_RST, synchronizer = 0
- Synchronous rst mid-transfer: strobes negate on the next edge and no ack is issued.

## Structure
- Package atahost_pkg holds:
  - state enumeration
  - DATA_ADR = 4'b0000, DEVHEAD_ADR = 4'b0110
  - cfg_sel codes
  - default timing constants
- Sub-module atahost_pio_tcnt: TWIDTH loadable down-counter with load and done outputs. One instance, reloaded at each phase entry.

## Test plan
- Default read, a=0, dev=0, iordy_en=0: ack exactly 36 edges after accept, q = DDi at the T2 exit edge, busy low at edge 63, diorn low for exactly 29 clocks.
- Device timing: write cfg_sel=2 with {3,1,5,1}, write a=6 with d=16'h0010, then read a=0. Expected: T1 = 2 clocks, T2 = 6, T4 = 2, Teoc = 4. A subsequent read of a=1 uses default timing.
- Write cycle: ddoe rises together with T1 entry and falls after T4. ddo = d throughout. diown pulse = T2+1 clocks.
- IORDY: iordy_en=1, iordy low until 10 clocks past the nominal T2 end. Expected: strobe negates 3 clocks after iordy rises; ack delayed by the same amount.
- cfg_we to the active set mid-transfer leaves the current phase lengths unchanged; the next transfer uses the new values. cfg_sel=3 write is ignored and reads 0.
- Assert rst during T2: strobes high next edge, no ack, all timing sets back to defaults, dev = 0.

Source files
------------

// File: rtl/atahost_pkg.sv
// ATA host PIO sequencer shared definitions.
// States, register addresses, timing-set selectors and reset timings.
package atahost_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T2W  = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;
  localparam logic [2:0] ST_TEOC = 3'd5;

  localparam logic [3:0] DATA_ADR    = 4'b0000;
  localparam logic [3:0] DEVHEAD_ADR = 4'b0110;

  localparam logic [1:0] SEL_CMD  = 2'd0;
  localparam logic [1:0] SEL_DEV0 = 2'd1;
  localparam logic [1:0] SEL_DEV1 = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  localparam int T1_DEF   = 6;
  localparam int T2_DEF   = 28;
  localparam int T4_DEF   = 2;
  localparam int TEOC_DEF = 23;

endpackage

// File: rtl/atahost_pio_dtseq_if.sv
// Host-side PIO request bus between the register decoder and the sequencer.
// master = register/decoder top, slave = sequencer.
interface atahost_pio_dtseq_if;
  logic        req;
  logic        we;
  logic [3:0]  a;
  logic [15:0] d;
  logic [15:0] q;
  logic        ack;
  logic        busy;

  modport master (
    output req, we, a, d,
    input  q, ack, busy
  );

  modport slave (
    input  req, we, a, d,
    output q, ack, busy
  );
endinterface

// File: rtl/atahost_pio_tcnt.sv
// Loadable down-counter timing one PIO phase.
// done is high while the count sits at zero.
module atahost_pio_tcnt #(
  parameter int TWIDTH = 8
) (
  input  logic              wb_clk_i,
  input  logic              rst_nreset_i,
  input  logic              rst,
  input  logic              ld,
  input  logic [TWIDTH-1:0] ld_val,
  output logic              done
);

  logic [TWIDTH-1:0] cnt;

  always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
    if (!rst_nreset_i) begin
      cnt <= '0;
    end else if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TWIDTH'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/atahost_pio_dtseq.sv
// ATA-3 PIO cycle sequencer with a command timing set and per-device data sets.
// Tracks the selected device by shadowing Device/Head register writes.
module atahost_pio_dtseq
  import atahost_pkg::*;
#(
  parameter int TWIDTH   = 8,
  parameter int T1_RST   = T1_DEF,
  parameter int T2_RST   = T2_DEF,
  parameter int T4_RST   = T4_DEF,
  parameter int TEOC_RST = TEOC_DEF
) (
  input  logic                wb_clk_i,
  input  logic                rst_nreset_i,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic [4*TWIDTH-1:0] cfg_d,
  output logic [4*TWIDTH-1:0] cfg_q,
  input  logic [2:0]          iordy_en,
  atahost_pio_dtseq_if.slave  bus,
  input  logic [15:0]         ddi,
  output logic [2:0]          da,
  output logic                cs0n,
  output logic                cs1n,
  output logic                diorn,
  output logic                diown,
  output logic [15:0]         ddo,
  output logic                ddoe,
  input  logic                iordy
);

  localparam int TW = TWIDTH;
  localparam logic [4*TW-1:0] SET_RST = {
    TW'(TEOC_RST), TW'(T4_RST), TW'(T2_RST), TW'(T1_RST)
  };

  logic [4*TW-1:0] tset0, tset1, tset2;
  logic [4*TW-1:0] set_a, tm_s;
  logic            ien_a, ien_s;
  logic [2:0]      state, state_n;
  logic            we_s;
  logic [3:0]      a_s;
  logic [15:0]     d_s, q_r;
  logic            ack_r, dev;
  logic            sync1, iordy_s;
  logic            acc, leave, ld, done;
  logic [TW-1:0]   ld_val;
  logic            act, strb;

  always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
    if (!rst_nreset_i) begin
      tset0 <= SET_RST;
      tset1 <= SET_RST;
      tset2 <= SET_RST;
    end else if (rst) begin
      tset0 <= SET_RST;
      tset1 <= SET_RST;
      tset2 <= SET_RST;
    end else if (cfg_we) begin
      case (cfg_sel)
        SEL_CMD:  tset0 <= cfg_d;
        SEL_DEV0: tset1 <= cfg_d;
        SEL_DEV1: tset2 <= cfg_d;
        default:  ;
      endcase
    end
  end

  always_comb begin
    cfg_q = '0;
    case (cfg_sel)
      SEL_CMD:  cfg_q = tset0;
      SEL_DEV0: cfg_q = tset1;
      SEL_DEV1: cfg_q = tset2;
      SEL_RSVD: cfg_q = '0;
      default:  cfg_q = '0;
    endcase
  end

  // Data-register accesses run on the fast set of the shadowed device.
  always_comb begin
    set_a = tset0;
    ien_a = iordy_en[0];
    if (bus.a == DATA_ADR) begin
      set_a = dev ? tset2 : tset1;
      ien_a = dev ? iordy_en[2] : iordy_en[1];
    end
  end

  assign acc = (state == ST_IDLE) && bus.req;

  always_comb begin
    state_n = state;
    ld      = 1'b0;
    ld_val  = '0;
    leave   = 1'b0;
    unique case (state)
      ST_IDLE: if (bus.req) begin
        state_n = ST_T1;
        ld      = 1'b1;
        ld_val  = set_a[TW-1:0];
      end
      ST_T1: if (done) begin
        state_n = ST_T2;
        ld      = 1'b1;
        ld_val  = tm_s[2*TW-1:TW];
      end
      ST_T2: if (done) begin
        if (ien_s && !iordy_s) begin
          state_n = ST_T2W;
        end else begin
          state_n = ST_T4;
          ld      = 1'b1;
          ld_val  = tm_s[3*TW-1:2*TW];
          leave   = 1'b1;
        end
      end
      ST_T2W: if (iordy_s) begin
        state_n = ST_T4;
        ld      = 1'b1;
        ld_val  = tm_s[3*TW-1:2*TW];
        leave   = 1'b1;
      end
      ST_T4: if (done) begin
        state_n = ST_TEOC;
        ld      = 1'b1;
        ld_val  = tm_s[4*TW-1:3*TW];
      end
      ST_TEOC: if (done) begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
    if (!rst_nreset_i) begin
      state   <= ST_IDLE;
      ack_r   <= 1'b0;
      q_r     <= '0;
      sync1   <= 1'b0;
      iordy_s <= 1'b0;
    end else if (rst) begin
      state   <= ST_IDLE;
      ack_r   <= 1'b0;
      q_r     <= '0;
      sync1   <= 1'b0;
      iordy_s <= 1'b0;
    end else begin
      state   <= state_n;
      ack_r   <= leave;
      sync1   <= iordy;
      iordy_s <= sync1;
      if (leave && !we_s) q_r <= ddi;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
    if (!rst_nreset_i) begin
      we_s  <= 1'b0;
      a_s   <= '0;
      d_s   <= '0;
      tm_s  <= SET_RST;
      ien_s <= 1'b0;
      dev   <= 1'b0;
    end else if (rst) begin
      we_s  <= 1'b0;
      a_s   <= '0;
      d_s   <= '0;
      tm_s  <= SET_RST;
      ien_s <= 1'b0;
      dev   <= 1'b0;
    end else if (acc) begin
      we_s  <= bus.we;
      a_s   <= bus.a;
      d_s   <= bus.d;
      tm_s  <= set_a;
      ien_s <= ien_a;
      if (bus.we && bus.a == DEVHEAD_ADR) dev <= bus.d[4];
    end
  end

  atahost_pio_tcnt #(.TWIDTH(TW)) u_tcnt (
    .wb_clk_i     (wb_clk_i),
    .rst_nreset_i (rst_nreset_i),
    .rst          (rst),
    .ld           (ld),
    .ld_val       (ld_val),
    .done         (done)
  );

  always_comb begin
    act  = 1'b0;
    strb = 1'b0;
    unique case (1'b1)
      (state == ST_T1):  act = 1'b1;
      (state == ST_T2),
      (state == ST_T2W): begin
        act  = 1'b1;
        strb = 1'b1;
      end
      (state == ST_T4):  act = 1'b1;
      default: ;
    endcase
  end

  assign cs0n  = !(act && !a_s[3]);
  assign cs1n  = !(act && a_s[3]);
  assign diorn = !(strb && !we_s);
  assign diown = !(strb && we_s);
  assign ddoe  = act && we_s;
  assign da    = a_s[2:0];
  assign ddo   = d_s;

  assign bus.q    = q_r;
  assign bus.ack  = ack_r;
  assign bus.busy = (state != ST_IDLE);

endmodule
